// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the FIFO.
// The master modport is the producer/FIFO side; the slave modport is the arbiter.
interface fifo_wr_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [OW-1:0]      owner;
    logic               write;
    logic [DW-1:0]      iData;

    modport master (
        output req, req_data, full,
        input  gnt, ack, owner, write, iData
    );

    modport slave (
        input  req, req_data, full,
        output gnt, ack, owner, write, iData
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port between NREQ producers,
// granting bounded bursts and stalling (never revoking) on FIFO full.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input logic           CLK,
    input logic           RSTn,
    fifo_wr_arb_if.slave  bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] gnt_int;
    logic [NREQ-1:0] ack_int;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            owner <= OW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Search starts just above the last owner, so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = owner;
        cand  = owner;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(owner) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found && !bus.full) begin
                    state_nxt = BUSY;
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!bus.req[owner]) begin
                    state_nxt = IDLE;
                end else if (!bus.full) begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt + CW'(1) == CW'(BURST)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_int = '0;
        if (state == BUSY) begin
            gnt_int = NREQ'(1) << owner;
        end
        ack_int = gnt_int & bus.req & {NREQ{~bus.full}};
    end

    assign bus.gnt   = gnt_int;
    assign bus.ack   = ack_int;
    assign bus.owner = owner;
    assign bus.write = |ack_int;
    assign bus.iData = (state == BUSY) ? bus.req_data[owner*DW +: DW] : '0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomized bench for fifo_wr_arb, checked cycle by cycle
// against a burst-level reference model of the arbitration rules.
module tb_fifo_wr_arb;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic CLK = 1'b0;
    logic RSTn;

    always #5 CLK = ~CLK;

    fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: who holds the port, how many beats they have used, per-requester word index.
    bit              m_busy;
    int              m_owner;
    int              m_taken;
    int              beat[NREQ];
    logic [NREQ-1:0] cur_req;
    logic            cur_full;
    logic [DW-1:0]   written[$];
    logic [NREQ-1:0] grant_log[$];
    logic [NREQ-1:0] prev_gnt;

    function automatic logic [DW-1:0] word_of(int i);
        return 8'(16 * i + beat[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_owner = NREQ - 1;
        m_taken = 0;
    endtask

    task automatic driveBus();
        bus.req  = cur_req;
        bus.full = cur_full;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*DW +: DW] = word_of(i);
        end
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_ack;
        logic [DW-1:0]   exp_data;
        exp_gnt  = m_busy ? NREQ'(1 << m_owner) : '0;
        exp_ack  = (m_busy && cur_req[m_owner] && !cur_full) ? exp_gnt : '0;
        exp_data = m_busy ? word_of(m_owner) : '0;
        check("gnt",   32'(bus.gnt),   32'(exp_gnt));
        check("ack",   32'(bus.ack),   32'(exp_ack));
        check("write", 32'(bus.write), 32'(exp_ack != 0));
        check("iData", 32'(bus.iData), 32'(exp_data));
        check("owner", 32'(bus.owner), 32'(m_owner));
        if (bus.write === 1'b1) written.push_back(bus.iData);
        if (bus.gnt !== '0 && prev_gnt === '0) grant_log.push_back(bus.gnt);
        prev_gnt = bus.gnt;
    endtask

    task automatic modelStep();
        if (m_busy) begin
            if (!cur_req[m_owner]) begin
                m_busy = 1'b0;
            end else if (!cur_full) begin
                beat[m_owner]++;
                m_taken++;
                if (m_taken == BURST) m_busy = 1'b0;
            end
        end else if (cur_req != 0 && !cur_full) begin
            for (int step = 1; step <= NREQ; step++) begin
                if (!m_busy && cur_req[(m_owner + step) % NREQ]) begin
                    m_owner = (m_owner + step) % NREQ;
                    m_busy  = 1'b1;
                end
            end
            m_taken = 0;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic f);
        cur_req  = r;
        cur_full = f;
        driveBus();
        #3;
        checkOutput();
        modelStep();
        @(posedge CLK);
        #1;
    endtask

    task automatic resetPulse();
        RSTn = 1'b0;
        modelReset();
        #3;
        checkOutput();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        int n0;
        logic [NREQ-1:0] r;

        for (int i = 0; i < NREQ; i++) beat[i] = 0;
        prev_gnt = '0;
        modelReset();
        RSTn     = 1'b0;
        cur_req  = 4'b1111;
        cur_full = 1'b0;
        driveBus();
        @(posedge CLK);
        #1;
        checkOutput();
        @(posedge CLK);
        #1;
        checkOutput();
        RSTn = 1'b1;

        // Round robin with everyone requesting: 5 grants and 20 writes in 25 cycles.
        applyStimulus(4'b1111, 1'b0);
        written.delete();
        grant_log.delete();
        repeat (25) applyStimulus(4'b1111, 1'b0);
        check("rr_writes", 32'(written.size()), 32'd20);
        check("rr_grants", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < grant_log.size() && i < 5; i++) begin
            check("rr_order", 32'(grant_log[i]), 32'(1 << (i % 4)));
        end
        for (int k = 0; k < written.size() && k < 20; k++) begin
            check("rr_data", 32'(written[k]), 32'(16 * ((k / 4) % 4) + 4 * (k / 16) + k % 4));
        end

        // Full stall after two beats of a burst.
        for (int i = 0; i < 20 && !(m_busy && m_taken == 2); i++) applyStimulus(4'b1111, 1'b0);
        n0 = written.size();
        repeat (3) applyStimulus(4'b1111, 1'b1);
        check("stall_writes", 32'(written.size() - n0), 32'd0);
        n0 = written.size();
        repeat (3) applyStimulus(4'b1111, 1'b0);
        check("stall_resume_writes", 32'(written.size() - n0), 32'd2);

        // Early release by requester 1, then a full burst for requester 2.
        cur_req = 4'b0010;
        driveBus();
        resetPulse();
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        n0 = written.size();
        repeat (6) applyStimulus(4'b0100, 1'b0);
        check("early_release_writes", 32'(written.size() - n0), 32'd4);

        // Randomized traffic with sticky requests and occasional full.
        r = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r, $urandom_range(0, 3) == 0);
        end

        // Single requester, then reset in the middle of its burst.
        cur_req = 4'b1000;
        driveBus();
        resetPulse();
        grant_log.delete();
        repeat (12) applyStimulus(4'b1000, 1'b0);
        check("single_grants", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 10 && !(m_busy && m_taken == 1); i++) applyStimulus(4'b1000, 1'b0);
        resetPulse();
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares the single write side of the 8-bit `fifo` between NREQ producers. It grants one producer at a time for a bounded burst, gates transfers on `full`, and drives the FIFO `write`/`iData` inputs directly. It sits between the producer blocks and the `fifo` instance; the read side of the FIFO is untouched.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..8.
- `DW`, 8, data width; must equal the FIFO data width.
- `BURST`, 4, maximum accepted beats per grant; must be ≥1.

- `CLK`  in  1  clock, rising edge.
- `RSTn`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester request; bit i = requester i has data.
- `req_data`  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- `full`  in  1  FIFO full flag.
- `gnt`  out  NREQ  one-hot grant; decoded from registered state only.
- `ack`  out  NREQ  beat accepted this cycle: `gnt & req & {NREQ{~full}}`.
- `owner`  out  clog2(NREQ)  index of the current or last owner (registered).
- `write`  out  1  FIFO write strobe = |ack.
- `iData`  out  DW  FIFO write data = `req_data[owner]` when BUSY, else 0.

## Operation
- States:
  - IDLE: `gnt`=0.
  - BUSY: `gnt`=one-hot(`owner`).
- Registers:
  - `state`.
  - `owner`: the last-grant pointer.
  - `cnt`: beat counter, width clog2(BURST+1).
- IDLE → BUSY when `req`≠0 and `full`=0.
  - The new `owner` is the first set `req` bit searching upward from `owner`+1, wrapping modulo NREQ.
  - `cnt` ← 0.
- IDLE with `req`=0 or `full`=1: stay in IDLE; `owner` and `cnt` hold.
- BUSY, accept cycle (`ack[owner]`=1): `cnt` ← `cnt`+1.
  - If `cnt`+1 == BURST → IDLE.
  - Otherwise stay in BUSY.
- BUSY with `req[owner]`=0: → IDLE next cycle, with no transfer this cycle.
- BUSY with `full`=1 and `req[owner]`=1: stall.
  - Stay in BUSY; `cnt` holds; `ack`=0, `write`=0.
  - The grant is kept; `full` never revokes ownership.
- `write`, `ack`, `iData` are combinational from registered state plus `req`, `req_data`, `full`. The FIFO samples them on the same edge that advances `cnt`.
- Requester protocol:
  - Hold `req_data` stable while `req` is high.
  - Advance to the next word on the cycle after `ack[i]`.
  - `req` may drop at any time; words that were not accepted are not written.
- Fairness: after any burst, the previous owner has the lowest priority at the next arbitration.

## Timing
- Reset values, applied asynchronously:
  - `state`=IDLE, `owner`=NREQ-1 so that requester 0 wins first, `cnt`=0.
  - `gnt`=0, `ack`=0, `write`=0, `iData`=0.
- Arbitration latency: `req` seen in IDLE at edge N gives `gnt` valid after edge N+1. The first `ack` can occur in cycle N+1.
- Throughput:
  - Up to BURST writes per grant.
  - Exactly one IDLE cycle between consecutive grants, including re-grant to the same requester.
  - Steady-state efficiency is BURST/(BURST+1).
- Writes into a full FIFO never occur: `write`=0 in any cycle where `full`=1.
- Reset mid-burst: outputs drop to zero immediately. Beats already acked remain in the FIFO; the partial burst is abandoned and there is no replay.
- A single active requester is re-granted every BURST+1 cycles.

## Test plan
- **Reset:** hold `RSTn`=0 with `req`=4'b1111 → `gnt`=0, `write`=0, `iData`=0. After release, the first `gnt`=4'b0001 one cycle later.
- **Round-robin:** all four requesters constantly requesting, `full`=0, BURST=4 → grant order 0,1,2,3,0. Each grant gives exactly 4 writes followed by 1 idle cycle. 20 writes occur in 25 cycles after the first grant.
- **Data routing:** requester i presents data 8'h10*i + beat, advancing on `ack` → FIFO receives 00,01,02,03,10,11,12,13,20… in order with no loss.
- **Full stall:** assert `full` mid-burst after beat 2 for 3 cycles → `write`=0 for those 3 cycles, `gnt` held, `cnt` held. Remaining 2 beats complete after `full` drops.
- **Early release:** requester 1 drops `req` after 1 beat → BUSY→IDLE next cycle. Requester 2 is granted on the following arbitration with a full burst of 4.
- **Single requester / reset mid-burst:** only `req[3]` active → `gnt`=4'b1000 repeatedly with a 1-cycle gap. Pulse `RSTn` low mid-burst → `write` drops immediately, and after release requester 3 is re-granted one cycle later.
